// File: rtl/wt_cache_pkg.sv
// Shared definitions for the write-through store buffer: pointer sizing and byte-lane merge.
package wt_cache_pkg;

  localparam int unsigned WBUF_DEPTH_DEF  = 8;
  localparam int unsigned WBUF_ADDR_W_DEF = 64;
  localparam int unsigned WBUF_DATA_W_DEF = 64;

  // Ring pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/store_coalesce_match.sv
// Parallel word-address comparator over buffer entries, qualified by a range mask.
module store_coalesce_match #(
  parameter int unsigned N  = 8,
  parameter int unsigned AW = 61
) (
  input  logic [N-1:0][AW-1:0] entry_addr,
  input  logic [N-1:0]         range_mask,
  input  logic [AW-1:0]        key,
  output logic                 hit,
  output logic [N-1:0]         hit_vec
);

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < N; i++) begin
      hit_vec[i] = range_mask[i] && (entry_addr[i] == key);
    end
  end

  assign hit = |hit_vec;

endmodule

// File: rtl/store_coalesce_buf.sv
// Write-through store buffer: in-order issue, outstanding-store limit, load lookup.
// Define CVA6_WBUF_COALESCE_EN to merge stores into a pending entry of the same word.
import wt_cache_pkg::*;

module store_coalesce_buf #(
  parameter int unsigned DEPTH           = WBUF_DEPTH_DEF,
  parameter int unsigned ADDR_W          = WBUF_ADDR_W_DEF,
  parameter int unsigned DATA_W          = WBUF_DATA_W_DEF,
  parameter int unsigned MAX_OUTSTANDING = 7
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [ADDR_W-1:0]            req_addr_i,
  input  logic [DATA_W-1:0]            req_data_i,
  input  logic [DATA_W/8-1:0]          req_be_i,
  output logic                         mem_valid_o,
  input  logic                         mem_ready_i,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [DATA_W-1:0]            mem_data_o,
  output logic [DATA_W/8-1:0]          mem_be_o,
  input  logic                         mem_ack_i,
  input  logic [ADDR_W-1:0]            lookup_addr_i,
  output logic                         lookup_hit_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding_o
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned WA_W  = ADDR_W - OFF_W;
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WA_W-1:0]   addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } wbuf_entry_t;

  wbuf_entry_t [DEPTH-1:0]      ent_q;
  logic [DEPTH-1:0][WA_W-1:0]   ent_addr;
  logic [PTR_W-1:0]             head_q, iss_q, tail_q;
  logic [PTR_W-1:0]             used, outstanding;
  logic [IDX_W-1:0]             iss_idx, tail_idx, dist_head;
  logic [DEPTH-1:0]             occ_mask, lookup_vec;
  logic [WA_W-1:0]              req_word, lookup_word;
  logic                         full, req_fire, issue_fire, ack_fire, alloc_en;
  logic                         unused_addr_bits;

  assign iss_idx     = iss_q[IDX_W-1:0];
  assign tail_idx    = tail_q[IDX_W-1:0];
  assign req_word    = req_addr_i[ADDR_W-1:OFF_W];
  assign lookup_word = lookup_addr_i[ADDR_W-1:OFF_W];
  assign unused_addr_bits = ^{req_addr_i[OFF_W-1:0], lookup_addr_i[OFF_W-1:0]};

  assign used        = tail_q - head_q;
  assign outstanding = iss_q - head_q;
  assign full        = (used == PTR_W'(DEPTH));

  assign req_ready_o   = ~full;
  assign mem_valid_o   = (iss_q != tail_q) && (outstanding < PTR_W'(MAX_OUTSTANDING));
  assign mem_addr_o    = {ent_q[iss_idx].addr, {OFF_W{1'b0}}};
  assign mem_data_o    = ent_q[iss_idx].data;
  assign mem_be_o      = ent_q[iss_idx].be;
  assign empty_o       = (used == '0);
  assign outstanding_o = CNT_W'(outstanding);

  // All-zero byte enables are accepted but neither allocate nor merge.
  assign req_fire   = req_valid_i && req_ready_o && (|req_be_i);
  assign issue_fire = mem_valid_o && mem_ready_i;
  assign ack_fire   = mem_ack_i && (outstanding != '0);

  always_comb begin
    occ_mask  = '0;
    ent_addr  = '0;
    dist_head = '0;
    for (int i = 0; i < DEPTH; i++) begin
      dist_head   = IDX_W'(i) - head_q[IDX_W-1:0];
      occ_mask[i] = ({1'b0, dist_head} < used);
      ent_addr[i] = ent_q[i].addr;
    end
  end

  store_coalesce_match #(.N(DEPTH), .AW(WA_W)) u_lookup_match (
    .entry_addr (ent_addr),
    .range_mask (occ_mask),
    .key        (lookup_word),
    .hit        (lookup_hit_o),
    .hit_vec    (lookup_vec)
  );

`ifdef CVA6_WBUF_COALESCE_EN
  logic [PTR_W-1:0]  pend_cnt;
  logic [IDX_W-1:0]  dist_iss;
  logic [DEPTH-1:0]  merge_mask, merge_vec;
  logic              merge_hit, merge_en;
  wbuf_entry_t       merge_old;
  logic [DATA_W-1:0] merge_data;

  assign pend_cnt = tail_q - iss_q;

  // The entry leaving on this edge is already committed to memory, so it is excluded.
  always_comb begin
    merge_mask = '0;
    dist_iss   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      dist_iss      = IDX_W'(i) - iss_idx;
      merge_mask[i] = ({1'b0, dist_iss} < pend_cnt);
    end
    if (issue_fire) merge_mask[iss_idx] = 1'b0;
  end

  store_coalesce_match #(.N(DEPTH), .AW(WA_W)) u_merge_match (
    .entry_addr (ent_addr),
    .range_mask (merge_mask),
    .key        (req_word),
    .hit        (merge_hit),
    .hit_vec    (merge_vec)
  );

  always_comb begin
    merge_old  = '0;
    merge_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (merge_vec[i]) merge_old = ent_q[i];
    end
    for (int b = 0; b < BE_W; b++) begin
      merge_data[8*b +: 8] = merge_byte(merge_old.data[8*b +: 8], req_data_i[8*b +: 8], req_be_i[b]);
    end
  end

  assign merge_en = req_fire && merge_hit;
  assign alloc_en = req_fire && !merge_hit;
`else
  assign alloc_en = req_fire;
`endif

  always_ff @(posedge clk_i) begin
    if (alloc_en) ent_q[tail_idx] <= '{addr: req_word, data: req_data_i, be: req_be_i};
`ifdef CVA6_WBUF_COALESCE_EN
    for (int i = 0; i < DEPTH; i++) begin
      if (merge_en && merge_vec[i]) begin
        ent_q[i].data <= merge_data;
        ent_q[i].be   <= merge_old.be | req_be_i;
      end
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      iss_q  <= '0;
      tail_q <= '0;
    end else begin
      if (alloc_en)   tail_q <= tail_q + PTR_W'(1);
      if (issue_fire) iss_q  <= iss_q + PTR_W'(1);
      if (ack_fire)   head_q <= head_q + PTR_W'(1);
    end
  end

endmodule
